// File: rtl/alu_pkg.sv
// Shared widths, sequencer state encoding and ALU function codes.
package alu_pkg;

    localparam int unsigned DW    = 16;
    localparam int unsigned NREGS = 8;
    localparam int unsigned AW    = $clog2(NREGS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } seq_state_e;

    localparam logic [2:0] FN_ADD   = 3'd0;
    localparam logic [2:0] FN_SUB   = 3'd1;
    localparam logic [2:0] FN_AND   = 3'd2;
    localparam logic [2:0] FN_OR    = 3'd3;
    localparam logic [2:0] FN_XOR   = 3'd4;
    localparam logic [2:0] FN_PASSA = 3'd5;
    localparam logic [2:0] FN_PASSB = 3'd6;
    localparam logic [2:0] FN_NOTA  = 3'd7;

endpackage

// File: rtl/alu_regfile.sv
// NREGS x DW register file: two async read ports, ALU write port over load port, r0 fixed at zero.
module alu_regfile #(
    parameter  int unsigned NREGS = 8,
    parameter  int unsigned DW    = 16,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b,
    input  logic          alu_we,
    input  logic [AW-1:0] alu_waddr,
    input  logic [DW-1:0] alu_wdata,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_waddr,
    input  logic [DW-1:0] ld_wdata
);

    logic [DW-1:0] mem [NREGS];

    // Entry 0 is only ever cleared, so it always reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i < NREGS; i++) begin
                if (alu_we && alu_waddr == AW'(i)) begin
                    mem[i] <= alu_wdata;
                end else if (ld_we && ld_waddr == AW'(i)) begin
                    mem[i] <= ld_wdata;
                end
            end
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue/writeback sequencer around the combinational ALU: IDLE accepts, EXEC writes back, WB reports.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter  int unsigned NREGS = alu_pkg::NREGS,
    parameter  int unsigned DW    = alu_pkg::DW,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [2:0]    instr_func,
    input  logic [AW-1:0] instr_dst,
    input  logic [AW-1:0] instr_srca,
    input  logic [AW-1:0] instr_srcb,
    input  logic          instr_cin,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic          alu_c,
    output logic [2:0]    alu_func,
    input  logic [DW-1:0] alu_w,
    input  logic          alu_z,
    input  logic          alu_n,
    output logic          res_valid,
    output logic [DW-1:0] res_data,
    output logic          flag_z,
    output logic          flag_n,
    output logic [15:0]   op_count
);

    seq_state_e    state;
    logic [AW-1:0] dst_q;
    logic [DW-1:0] rd_a;
    logic [DW-1:0] rd_b;
    logic          wb_en_c;

    assign wb_en_c = (state == ST_EXEC);

    alu_regfile #(
        .NREGS (NREGS),
        .DW    (DW)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .raddr_a   (instr_srca),
        .raddr_b   (instr_srcb),
        .rdata_a   (rd_a),
        .rdata_b   (rd_b),
        .alu_we    (wb_en_c),
        .alu_waddr (dst_q),
        .alu_wdata (alu_w),
        .ld_we     (ld_en),
        .ld_waddr  (ld_addr),
        .ld_wdata  (ld_data)
    );

    // instr_ready is a flop so it stays low through reset and rises one edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            instr_ready <= 1'b0;
            dst_q       <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_c       <= 1'b0;
            alu_func    <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            flag_z      <= 1'b0;
            flag_n      <= 1'b0;
            op_count    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    res_valid <= 1'b0;
                    if (instr_valid && instr_ready) begin
                        alu_a       <= rd_a;
                        alu_b       <= rd_b;
                        alu_c       <= instr_cin;
                        alu_func    <= instr_func;
                        dst_q       <= instr_dst;
                        instr_ready <= 1'b0;
                        state       <= ST_EXEC;
                    end else begin
                        instr_ready <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    res_data  <= alu_w;
                    flag_z    <= alu_z;
                    flag_n    <= alu_n;
                    res_valid <= 1'b1;
                    state     <= ST_WB;
                end
                ST_WB: begin
                    res_valid   <= 1'b0;
                    op_count    <= op_count + 16'(1);
                    instr_ready <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: begin
                    res_valid   <= 1'b0;
                    instr_ready <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 16-bit ALU closing the loop.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  instr_func;
    logic [2:0]  instr_dst;
    logic [2:0]  instr_srca;
    logic [2:0]  instr_srcb;
    logic        instr_cin;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_c;
    logic [2:0]  alu_func;
    logic [15:0] alu_w;
    logic        alu_z;
    logic        alu_n;
    logic        res_valid;
    logic [15:0] res_data;
    logic        flag_z;
    logic        flag_n;
    logic [15:0] op_count;

    int checks = 0;
    int errors = 0;
    logic [15:0] rb_a;
    logic [15:0] rb_b;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_func  (instr_func),
        .instr_dst   (instr_dst),
        .instr_srca  (instr_srca),
        .instr_srcb  (instr_srcb),
        .instr_cin   (instr_cin),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_c       (alu_c),
        .alu_func    (alu_func),
        .alu_w       (alu_w),
        .alu_z       (alu_z),
        .alu_n       (alu_n),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .flag_z      (flag_z),
        .flag_n      (flag_n),
        .op_count    (op_count)
    );

    // Behavioural ALU standing in for the real combinational block.
    always_comb begin
        alu_w = '0;
        case (alu_func)
            FN_ADD:   alu_w = alu_a + alu_b + 16'(alu_c);
            FN_SUB:   alu_w = alu_a - alu_b - 16'(alu_c);
            FN_AND:   alu_w = alu_a & alu_b;
            FN_OR:    alu_w = alu_a | alu_b;
            FN_XOR:   alu_w = alu_a ^ alu_b;
            FN_PASSA: alu_w = alu_a;
            FN_PASSB: alu_w = alu_b;
            default:  alu_w = ~alu_a;
        endcase
        alu_z = (alu_w == 16'h0000);
        alu_n = alu_w[15];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (instr_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(instr_ready), 32'd1);
    endtask

    // Returns at the negedge inside the EXEC cycle.
    task automatic issue(input logic [2:0] f, input logic [2:0] d, input logic [2:0] sa,
                         input logic [2:0] sb, input logic c);
        wait_ready();
        instr_valid = 1'b1;
        instr_func  = f;
        instr_dst   = d;
        instr_srca  = sa;
        instr_srcb  = sb;
        instr_cin   = c;
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic finish_op();
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic load(input logic [2:0] a, input logic [15:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic readback(input logic [2:0] ra, input logic [2:0] rb);
        issue(FN_PASSA, 3'd0, ra, rb, 1'b0);
        rb_a = alu_a;
        rb_b = alu_b;
        finish_op();
    endtask

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; instr_func = '0; instr_dst = '0;
        instr_srca = '0; instr_srcb = '0; instr_cin = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(instr_ready), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(instr_ready), 32'd1);

        // Reset in the middle of EXEC discards the instruction.
        load(3'd1, 16'h1234);
        issue(FN_ADD, 3'd1, 3'd1, 3'd1, 1'b0);
        chk("midrst_alu_a", 32'(alu_a), 32'h1234);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(instr_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst_no_res_valid", 32'(res_valid), 32'd0);
        end
        chk("midrst_op_count", 32'(op_count), 32'd0);
        readback(3'd1, 3'd1);
        chk("midrst_r1", 32'(rb_a), 32'd0);

        // Basic SUB: 5 - 3 = 2 into r3.
        load(3'd1, 16'h0005);
        load(3'd2, 16'h0003);
        issue(FN_SUB, 3'd3, 3'd1, 3'd2, 1'b0);
        chk("sub_alu_a", 32'(alu_a), 32'h0005);
        chk("sub_alu_b", 32'(alu_b), 32'h0003);
        chk("sub_alu_func", 32'(alu_func), 32'd1);
        chk("sub_exec_res_valid", 32'(res_valid), 32'd0);
        @(negedge clk);
        chk("sub_wb_res_valid", 32'(res_valid), 32'd1);
        chk("sub_res_data", 32'(res_data), 32'h0002);
        chk("sub_flag_z", 32'(flag_z), 32'd0);
        chk("sub_flag_n", 32'(flag_n), 32'd0);
        @(negedge clk);
        chk("sub_res_valid_drop", 32'(res_valid), 32'd0);
        chk("sub_op_count", 32'(op_count), 32'd2);
        readback(3'd3, 3'd3);
        chk("sub_r3", 32'(rb_a), 32'h0002);

        // Carry-in and zero flag.
        issue(FN_SUB, 3'd6, 3'd1, 3'd2, 1'b1);
        chk("cin_alu_c", 32'(alu_c), 32'd1);
        @(negedge clk);
        chk("cin_res_data", 32'(res_data), 32'h0001);
        @(negedge clk);
        issue(FN_SUB, 3'd7, 3'd1, 3'd1, 1'b0);
        @(negedge clk);
        chk("zero_res_data", 32'(res_data), 32'h0000);
        chk("zero_flag_z", 32'(flag_z), 32'd1);
        @(negedge clk);

        // Back-to-back: instr_valid held high for three accepts.
        wait_ready();
        instr_valid = 1'b1; instr_func = FN_ADD; instr_dst = 3'd4;
        instr_srca = 3'd1; instr_srcb = 3'd2; instr_cin = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk("b2b_ready", 32'(instr_ready), (k % 3 == 0) ? 32'd1 : 32'd0);
            if (k == 7) instr_valid = 1'b0;
        end
        chk("b2b_op_count", 32'(op_count), 32'd8);
        chk("b2b_res_data", 32'(res_data), 32'h0008);

        // Load and ALU writeback on the same edge, same address: ALU wins.
        issue(FN_ADD, 3'd3, 3'd1, 3'd2, 1'b0);
        ld_en = 1'b1; ld_addr = 3'd3; ld_data = 16'hAAAA;
        @(negedge clk);
        ld_en = 1'b0;
        @(negedge clk);
        readback(3'd3, 3'd3);
        chk("coll_same_r3", 32'(rb_a), 32'h0008);

        // Different addresses: both land.
        issue(FN_ADD, 3'd3, 3'd1, 3'd2, 1'b0);
        ld_en = 1'b1; ld_addr = 3'd4; ld_data = 16'hAAAA;
        @(negedge clk);
        ld_en = 1'b0;
        @(negedge clk);
        readback(3'd3, 3'd4);
        chk("coll_diff_r3", 32'(rb_a), 32'h0008);
        chk("coll_diff_r4", 32'(rb_b), 32'hAAAA);

        // Loads to r0 are dropped.
        load(3'd0, 16'hFFFF);
        load(3'd5, 16'h8000);
        readback(3'd0, 3'd5);
        chk("ld_r0_dropped", 32'(rb_a), 32'h0000);
        chk("ld_r5", 32'(rb_b), 32'h8000);

        // ALU write to r0: result and flags update, r0 stays zero.
        issue(FN_PASSA, 3'd0, 3'd5, 3'd0, 1'b0);
        @(negedge clk);
        chk("r0wb_res_data", 32'(res_data), 32'h8000);
        chk("r0wb_flag_n", 32'(flag_n), 32'd1);
        chk("r0wb_flag_z", 32'(flag_z), 32'd0);
        @(negedge clk);
        readback(3'd0, 3'd0);
        chk("r0wb_r0", 32'(rb_a), 32'h0000);
        chk("op_count_15", 32'(op_count), 32'd15);

        // Counter wrap from 0xFFFF.
        force dut.op_count = 16'hFFFF;
        #1;
        release dut.op_count;
        #1;
        chk("wrap_preload", 32'(op_count), 32'hFFFF);
        issue(FN_ADD, 3'd6, 3'd1, 3'd2, 1'b0);
        finish_op();
        chk("wrap_op_count", 32'(op_count), 32'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Sequential issue/writeback stage wrapped around the 16-bit combinational ALU (operands a, b, carry-in c, 3-bit func; outputs w, zero, neg).
- Accepts register-addressed ALU instructions over a valid/ready handshake and reads operands from an internal 8x16 register file.
- Drives the ALU from registered operands, then captures w/zero/neg back into the register file and a flag register.
- Provides the clocked datapath the ALU needs to run programs instead of raw testbench stimulus.

Parameters:
- NREGS, 8, register-file depth (power of 2; address width = log2(NREGS)).
- DW, 16, datapath width; must match the ALU width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  sequencer can accept an instruction.
- instr_func  in  3  ALU function code, passed through opaque.
- instr_dst  in  3  destination register.
- instr_srca  in  3  operand A register.
- instr_srcb  in  3  operand B register.
- instr_cin  in  1  carry-in for the ALU.
- ld_en  in  1  external register load.
- ld_addr  in  3  load address.
- ld_data  in  16  load data.
- alu_a  out  16  ALU operand A (registered).
- alu_b  out  16  ALU operand B (registered).
- alu_c  out  1  ALU carry-in (registered).
- alu_func  out  3  ALU function (registered).
- alu_w  in  16  ALU result.
- alu_z  in  1  ALU zero flag.
- alu_n  in  1  ALU negative flag.
- res_valid  out  1  one-cycle pulse: result written back.
- res_data  out  16  last written-back result.
- flag_z  out  1  last captured zero flag.
- flag_n  out  1  last captured negative flag.
- op_count  out  16  completed-instruction counter.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all registers, rf entries, alu_* outputs, res_*, flags and op_count = 0. instr_ready=0 while rst_n=0. A reset mid-instruction discards the instruction with no writeback.
- FSM states: IDLE, EXEC, WB. instr_ready=1 only in IDLE.
- IDLE: on a rising edge with instr_valid=1, accept the instruction.
  - alu_a <= rf[srca], alu_b <= rf[srcb], alu_c <= cin, alu_func <= func.
  - Latch dst internally; go to EXEC.
  - Otherwise stay in IDLE; alu_* hold their values.
- EXEC: the ALU settles combinationally.
  - On the edge: rf[dst] <= alu_w, res_data <= alu_w, flag_z <= alu_z, flag_n <= alu_n; go to WB.
- WB: res_valid=1 for exactly this cycle; op_count increments by 1 on the edge, wrapping 0xFFFF->0x0000. Return to IDLE.
- Timing and throughput:
  - Accept edge T; writeback edge T+1; res_valid high in cycle T+1..T+2.
  - Next accept no earlier than edge T+2, so peak rate is one instruction per 3 cycles.
- Register 0 reads as 0 always; writes to r0 (ALU or load) are dropped. res_data/flags still update on an ALU write to r0.
- ld_en is honoured in every state: rf[ld_addr] <= ld_data on the edge.
- Load vs ALU writeback on the same edge and same address: ALU writeback wins. Different addresses: both writes happen.
- Operand read on the accept edge sees pre-edge contents; there is no bypass from a simultaneous load or writeback.
- instr_valid while busy is ignored; the producer must hold the instruction until instr_ready is high.
- alu_* and flag outputs are registered only; no combinational path from instr_* to alu_*.

Decomposition:
- Shared package alu_pkg: DW, register-address width, FSM state encoding (IDLE=2'd0, EXEC=2'd1, WB=2'd2), func code constants shared with the ALU.
- One sub-module: alu_regfile (NREGS x DW; 2 async read ports; 2 write ports with ALU-over-load priority; r0 hardwired to zero).
- The FSM and counter stay in the top module.

Test Plan:
- Reset mid-EXEC (rst_n low for 1 cycle) -> res_valid never pulses, op_count=0, rf[1] read back 0.
- Load r1=0x0005, r2=0x0003, then issue func=1, dst=3, srca=1, srcb=2, cin=0:
  - alu_a=0x0005 and alu_b=0x0003 one cycle after accept.
  - r3, res_data and flags hold the ALU's w/z/n.
  - res_valid high exactly 1 cycle; op_count=1.
- Back-to-back instr_valid held high for 3 instructions -> instr_ready pattern 1,0,0 repeating; accepts 3 cycles apart; op_count=3.
- ld_en to r3 with 0xAAAA on the same edge as ALU writeback to r3 -> r3 equals ALU result. Repeat with ld_addr=4 -> r3=ALU result and r4=0xAAAA.
- Instruction with dst=0, ALU model returning 0x8000 -> res_data=0x8000, flag_n=1, subsequent read of r0 gives 0x0000.
- Preload op_count to 0xFFFF via 65535 instructions (or force) and issue one more -> op_count=0x0000.
